// File: rtl/datapath_gr10.sv
// Fibonacci datapath for the gr10 controller: two operand buses, an ALU,
// five working registers and the registered status flags the controller reads.
module datapath_gr10 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic [2:0]   f,
    input  logic         tsw,
    input  logic         tn,
    input  logic         tm,
    input  logic         tp,
    input  logic         tone,
    input  logic         tpp,
    input  logic         tout,
    input  logic         ldn,
    input  logic         ldm,
    input  logic         ldp,
    input  logic         ldpp,
    input  logic         ldout,
    input  logic         over,
    output logic         bo,
    output logic [W-1:0] result,
    output logic         done,
    output logic         ovf,
    output logic         err
);

    localparam int unsigned WS = W + 1;

    localparam logic [2:0] F_ZERO = 3'd0;
    localparam logic [2:0] F_AND  = 3'd1;
    localparam logic [2:0] F_A    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_SUB  = 3'd4;
    localparam logic [2:0] F_ADD  = 3'd5;
    localparam logic [2:0] F_OR   = 3'd6;
    localparam logic [2:0] F_XOR  = 3'd7;

    logic [W-1:0]  n_q, m_q, p_q, pp_q, out_q;
    logic          bo_q, done_q, ovf_q, err_q;

    logic [W-1:0]  bus_a, bus_b, alu_r;
    logic [WS-1:0] sum;
    logic          a_multi, b_multi, contention, new_run, carry;

    // Wired-OR buses; an undriven bus reads zero.
    always_comb begin
        bus_a = ({W{tsw}} & sw)
              | ({W{tn}}  & n_q)
              | ({W{tm}}  & m_q)
              | ({W{tp}}  & p_q);
        bus_b = ({W{tone}} & W'(1))
              | ({W{tpp}}  & pp_q)
              | ({W{tout}} & out_q);
    end

    // More than one enable on either bus is flagged as contention.
    always_comb begin
        a_multi    = (tsw & tn) | (tsw & tm) | (tsw & tp)
                   | (tn & tm)  | (tn & tp)  | (tm & tp);
        b_multi    = (tone & tpp) | (tone & tout) | (tpp & tout);
        contention = a_multi | b_multi;
        new_run    = tsw & ldn;
    end

    always_comb begin
        sum   = WS'(bus_a) + WS'(bus_b);
        carry = sum[W];
        alu_r = '0;
        case (f)
            F_ZERO: alu_r = '0;
            F_AND:  alu_r = bus_a & bus_b;
            F_A:    alu_r = bus_a;
            F_B:    alu_r = bus_b;
            F_SUB:  alu_r = bus_a - bus_b;
            F_ADD:  alu_r = sum[W-1:0];
            F_OR:   alu_r = bus_a | bus_b;
            F_XOR:  alu_r = bus_a ^ bus_b;
        endcase
    end

    // Working registers; reset blocks any load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            m_q   <= '0;
            p_q   <= '0;
            pp_q  <= '0;
            out_q <= '0;
        end else begin
            if (ldn)   n_q   <= alu_r;
            if (ldm)   m_q   <= alu_r;
            if (ldp)   p_q   <= alu_r;
            if (ldpp)  pp_q  <= alu_r;
            if (ldout) out_q <= alu_r;
        end
    end

    // Status flags; a set on the new-run edge takes precedence over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bo_q   <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (f == F_SUB)
                bo_q <= (bus_a <= bus_b);

            if ((f == F_ADD) && carry)
                ovf_q <= 1'b1;
            else if (new_run)
                ovf_q <= 1'b0;

            if (contention)
                err_q <= 1'b1;
            else if (new_run)
                err_q <= 1'b0;

            if (over)
                done_q <= 1'b1;
            else if (new_run)
                done_q <= 1'b0;
        end
    end

    assign result = p_q;
    assign bo     = bo_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule

// File: tb/tb_datapath_gr10.sv
// Directed bench for datapath_gr10: vector table for ALU/flag behaviour plus
// full controller-style Fibonacci runs and a mid-run reset.
module tb_datapath_gr10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [2:0] f;
    logic       tsw, tn, tm, tp, tone, tpp, tout;
    logic       ldn, ldm, ldp, ldpp, ldout, over;
    logic       bo, done, ovf, err;
    logic [7:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [3:0] A_NO = 4'b0000, A_SW = 4'b1000, A_N = 4'b0100,
                           A_M  = 4'b0010, A_P  = 4'b0001;
    localparam logic [2:0] B_NO = 3'b000, B_ONE = 3'b100, B_PP = 3'b010, B_OUT = 3'b001;
    localparam logic [4:0] L_NO = 5'b00000, L_N = 5'b10000, L_M = 5'b01000,
                           L_P  = 5'b00100, L_PP = 5'b00010, L_OUT = 5'b00001;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] f;
        logic [3:0] a;
        logic [2:0] b;
        logic [4:0] ld;
        logic       over;
        logic [7:0] e_res;
        logic       e_bo;
        logic       e_done;
        logic       e_ovf;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    datapath_gr10 #(.W(8)) dut (
        .clk(clk), .rst(rst), .sw(sw), .f(f),
        .tsw(tsw), .tn(tn), .tm(tm), .tp(tp),
        .tone(tone), .tpp(tpp), .tout(tout),
        .ldn(ldn), .ldm(ldm), .ldp(ldp), .ldpp(ldpp), .ldout(ldout),
        .over(over), .bo(bo), .result(result), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [7:0] s, input logic [2:0] ff,
                                input logic [3:0] a, input logic [2:0] b,
                                input logic [4:0] ld, input logic ov,
                                input logic [7:0] r, input logic eb,
                                input logic ed, input logic eo, input logic ee);
        vec_t v;
        v.sw = s; v.f = ff; v.a = a; v.b = b; v.ld = ld; v.over = ov;
        v.e_res = r; v.e_bo = eb; v.e_done = ed; v.e_ovf = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic check_all(input string name, input logic [7:0] r, input logic eb,
                             input logic ed, input logic eo, input logic ee);
        chk({name, ".result"}, 32'(result), 32'(r));
        chk({name, ".bo"},     32'(bo),     32'(eb));
        chk({name, ".done"},   32'(done),   32'(ed));
        chk({name, ".ovf"},    32'(ovf),    32'(eo));
        chk({name, ".err"},    32'(err),    32'(ee));
    endtask

    // Apply one control word for one cycle; outputs are sampled 1 after the edge.
    task automatic drive(input logic [7:0] s, input logic [2:0] ff, input logic [3:0] a,
                         input logic [2:0] b, input logic [4:0] ld, input logic ov);
        sw = s;
        f  = ff;
        {tsw, tn, tm, tp} = a;
        {tone, tpp, tout} = b;
        {ldn, ldm, ldp, ldpp, ldout} = ld;
        over = ov;
        @(posedge clk);
        #1;
    endtask

    // Controller-style run; the loop follows bo like the real controller.
    task automatic run_fib(input logic [7:0] nn, input logic [7:0] exp_res, input logic exp_ovf);
        logic [7:0] m, pa, pb, t;
        int         iter, exp_iter;
        logic       exited;
        exp_iter = (nn > 8'd2) ? int'(nn) - 2 : 0;
        iter     = 0;
        exited   = 1'b0;
        drive(nn,   3'd2, A_SW, B_NO,  L_N,  1'b0);
        drive(8'h0, 3'd4, A_N,  B_ONE, L_M,  1'b0);
        drive(8'h0, 3'd3, A_NO, B_ONE, L_P,  1'b0);
        drive(8'h0, 3'd3, A_NO, B_ONE, L_PP, 1'b0);
        m  = nn - 8'd1;
        pa = 8'd1;
        pb = 8'd1;
        chk($sformatf("fib%0d.p_init", nn), 32'(result), 32'(pa));
        for (int k = 0; k < 64; k++) begin
            drive(8'h0, 3'd4, A_M, B_ONE, L_NO, 1'b0);
            chk($sformatf("fib%0d.bo_it%0d", nn, k), 32'(bo), 32'(m <= 8'd1));
            if (bo) begin
                exited = 1'b1;
                break;
            end
            drive(8'h0, 3'd5, A_P,  B_PP,  L_OUT, 1'b0);
            drive(8'h0, 3'd2, A_P,  B_NO,  L_PP,  1'b0);
            drive(8'h0, 3'd3, A_NO, B_OUT, L_P,   1'b0);
            drive(8'h0, 3'd4, A_M,  B_ONE, L_M,   1'b0);
            t  = pa + pb;
            pb = pa;
            pa = t;
            m  = m - 8'd1;
            iter++;
            chk($sformatf("fib%0d.p_it%0d", nn, k), 32'(result), 32'(pa));
        end
        chk($sformatf("fib%0d.exited", nn), 32'(exited), 32'd1);
        chk($sformatf("fib%0d.iters", nn), 32'(iter), 32'(exp_iter));
        drive(8'h0, 3'd0, A_NO, B_NO, L_NO, 1'b1);
        check_all($sformatf("fib%0d.end", nn), exp_res, 1'b1, 1'b1, exp_ovf, 1'b0);
    endtask

    initial begin
        logic [7:0] alu_exp [8];
        logic [7:0] prev;
        alu_exp = '{8'h00, 8'h24, 8'hA5, 8'h3C, 8'h69, 8'hE1, 8'hBD, 8'h99};

        // Contention, then err clear by new run
        vq.push_back(mk(8'h0C, 3'd2, A_SW,      B_NO,  L_N,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(8'h03, 3'd2, A_SW,      B_NO,  L_M,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(8'h00, 3'd2, A_N | A_M, B_NO,  L_OUT, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(8'h00, 3'd3, A_NO,      B_OUT, L_P,   1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(8'h00, 3'd0, A_NO,      B_NO,  L_NO,  1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(8'h05, 3'd2, A_SW,      B_NO,  L_N,   1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0));
        // ALU sweep: A=sw=0xA5, B=PP=0x3C, each result via OUT into P
        vq.push_back(mk(8'h3C, 3'd2, A_SW,      B_NO,  L_PP,  1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0));
        prev = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            vq.push_back(mk(8'hA5, 3'(k), A_SW, B_PP,  L_OUT, 1'b0, prev, 1'b0, 1'b0, 1'b0, 1'b0));
            vq.push_back(mk(8'h00, 3'd3,  A_NO, B_OUT, L_P,   1'b0, alu_exp[k], 1'b0, 1'b0, 1'b0, 1'b0));
            prev = alu_exp[k];
        end
        // bo: equal sets, non-compare holds, greater clears
        vq.push_back(mk(8'h3C, 3'd4, A_SW,      B_PP,  L_NO,  1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(8'h00, 3'd0, A_NO,      B_NO,  L_NO,  1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(8'h3D, 3'd4, A_SW,      B_PP,  L_NO,  1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0));
        // Overflow: 0xC4+0x3C wraps to 0; set beats new-run clear
        vq.push_back(mk(8'hC4, 3'd5, A_SW,      B_PP,  L_OUT, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(8'h00, 3'd3, A_NO,      B_OUT, L_P,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(8'hC4, 3'd5, A_SW,      B_PP,  L_N,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(8'h01, 3'd2, A_SW,      B_NO,  L_N,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        // err set beats new-run clear; B-bus contention uses OR value (1|0x3C)
        vq.push_back(mk(8'h01, 3'd2, A_SW | A_N, B_NO, L_N,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(8'h00, 3'd3, A_NO, B_ONE | B_PP, L_P, 1'b0, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(8'h00, 3'd2, A_SW,      B_NO,  L_N,   1'b0, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b0));
        // done set by over, held, cleared by new run; undriven bus reads 0
        vq.push_back(mk(8'h00, 3'd0, A_NO,      B_NO,  L_NO,  1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(8'h00, 3'd0, A_NO,      B_NO,  L_NO,  1'b0, 8'h3D, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(8'h00, 3'd2, A_SW,      B_NO,  L_N,   1'b0, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(8'h00, 3'd2, A_NO,      B_NO,  L_P,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        rst = 1'b1;
        drive(8'hFF, 3'd5, A_SW, B_ONE, L_P, 1'b1);
        drive(8'hFF, 3'd5, A_SW, B_ONE, L_P, 1'b1);
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].sw, vq[i].f, vq[i].a, vq[i].b, vq[i].ld, vq[i].over);
            check_all($sformatf("vec%0d", i), vq[i].e_res, vq[i].e_bo,
                      vq[i].e_done, vq[i].e_ovf, vq[i].e_err);
        end

        run_fib(8'd5,  8'd5,   1'b0);
        run_fib(8'd1,  8'd1,   1'b0);
        run_fib(8'd13, 8'd233, 1'b0);
        run_fib(8'd14, 8'd121, 1'b1);

        // Mid-loop reset while P would load OUT=2
        drive(8'd5, 3'd2, A_SW, B_NO,  L_N,   1'b0);
        drive(8'h0, 3'd4, A_N,  B_ONE, L_M,   1'b0);
        drive(8'h0, 3'd3, A_NO, B_ONE, L_P,   1'b0);
        drive(8'h0, 3'd3, A_NO, B_ONE, L_PP,  1'b0);
        drive(8'h0, 3'd4, A_M,  B_ONE, L_NO,  1'b0);
        drive(8'h0, 3'd5, A_P,  B_PP,  L_OUT, 1'b0);
        drive(8'h0, 3'd2, A_P,  B_NO,  L_PP,  1'b0);
        rst = 1'b1;
        drive(8'h0, 3'd3, A_NO, B_OUT, L_P,   1'b1);
        rst = 1'b0;
        check_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h0, 3'd3, A_NO, B_OUT, L_P, 1'b0);
        chk("midrst.out", 32'(result), 32'd0);
        drive(8'h0, 3'd3, A_NO, B_PP,  L_P, 1'b0);
        chk("midrst.pp", 32'(result), 32'd0);
        drive(8'h0, 3'd2, A_N,  B_NO,  L_P, 1'b0);
        chk("midrst.n", 32'(result), 32'd0);
        drive(8'h0, 3'd2, A_M,  B_NO,  L_P, 1'b0);
        chk("midrst.m", 32'(result), 32'd0);
        run_fib(8'd5, 8'd5, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
